// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin front end for a shared ALU.
//                Accepts one command, holds it on alu_cmd for a latency
//                that depends on the floating bit, captures the ALU result
//                and holds it until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int INT_LAT = 1,   // EXEC cycles for integer commands (1..16)
    parameter int FP_LAT  = 3    // EXEC cycles for floating commands (1..16)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [269:0]   req_bits,
    output logic [134:0]   alu_cmd,
    input  logic [63:0]    alu_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [63:0]    rsp_y,
    output logic           busy
);

    // Counter preload values: the counter runs LAT-1 .. 0, one EXEC cycle each.
    localparam logic [3:0] c_INT_CNT = 4'(INT_LAT - 1);
    localparam logic [3:0] c_FP_CNT  = 4'(FP_LAT - 1);

    // Bit position of the floating flag inside a 135-bit command slot.
    localparam int c_FP_BIT = 131;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_rr_ptr;
    logic [3:0]     r_cnt;

    logic           w_grant_vld;
    logic           w_grant_idx;
    logic [1:0]     w_req_ready;
    logic           w_accept;
    logic [134:0]   w_slot;
    logic           w_exec_done;

    // Grant selection: the round-robin favourite wins if valid, otherwise
    // the other requester if valid, so a lone requester never waits.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        if (req_valid[r_rr_ptr]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_rr_ptr;
        end else if (req_valid[~r_rr_ptr]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = ~r_rr_ptr;
        end
    end

    // Ready is offered only in IDLE and only to the granted requester; it is
    // forced low while reset is asserted so nothing can be taken that cycle.
    always_comb begin
        w_req_ready = 2'b00;
        if ((r_state == S_IDLE) && !rst && w_grant_vld) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready   = w_req_ready;
    assign w_accept    = |(req_valid & w_req_ready);
    assign w_slot      = w_grant_idx ? req_bits[269:135] : req_bits[134:0];
    assign w_exec_done = (r_cnt == 4'd0);
    assign busy        = (r_state != S_IDLE) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_exec_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: command latch, latency counter, response capture and the
    // round-robin pointer. Values not explicitly updated are retained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= 1'b0;
            r_cnt     <= 4'd0;
            alu_cmd   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_cmd  <= w_slot;
                        rsp_id   <= w_grant_idx;
                        r_rr_ptr <= ~w_grant_idx;
                        r_cnt    <= w_slot[c_FP_BIT] ? c_FP_CNT : c_INT_CNT;
                    end
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        rsp_y     <= alu_y;
                        rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [269:0]   req_bits;
    logic [134:0]   alu_cmd;
    logic [63:0]    alu_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [63:0]    rsp_y;
    logic           busy;

    int vectors;
    int miscompares;

    alu_arbiter #(
        .INT_LAT (1),
        .FP_LAT  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bits  (req_bits),
        .alu_cmd   (alu_cmd),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [134:0] mk_cmd(input logic [2:0] op, input logic fl,
                                            input logic form, input logic [1:0] prec,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        return {op, fl, form, prec, a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [134:0] obs, input logic [134:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [134:0] cmd_a, cmd_b, cmd_f, cmd_f0, cmd_r0, cmd_r1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmd_a  = mk_cmd(3'd0, 1'b0, 1'b1, 2'd0, 32'd1, 32'd2, 32'd3, 32'd2);
        cmd_b  = mk_cmd(3'd2, 1'b0, 1'b0, 2'd1, 32'h11, 32'h22, 32'h33, 32'h44);
        cmd_f  = mk_cmd(3'd5, 1'b1, 1'b1, 2'd2, 32'hA, 32'hB, 32'hC, 32'hD);
        cmd_f0 = mk_cmd(3'd1, 1'b1, 1'b0, 2'd3, 32'h5, 32'h6, 32'h7, 32'h8);
        cmd_r0 = mk_cmd(3'd3, 1'b0, 1'b0, 2'd0, 32'h100, 32'h200, 32'h300, 32'h400);
        cmd_r1 = mk_cmd(3'd4, 1'b0, 1'b1, 2'd1, 32'h500, 32'h600, 32'h700, 32'h800);

        rst       = 1'b1;
        req_valid = 2'b00;
        req_bits  = '0;
        alu_y     = '0;
        rsp_ready = 1'b0;

        // ---- reset state ----
        step();
        chk("rst_alu_cmd",   alu_cmd,   135'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id",    rsp_id,    1'b0);
        chk("rst_rsp_y",     rsp_y,     64'd0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        rst = 1'b0;
        step();

        // ---- integer add, then backpressure in RESP ----
        req_bits  = {cmd_b, cmd_a};
        req_valid = 2'b01;
        alu_y     = 64'd6;
        #1;
        chk("add_ready", req_ready, 2'b01);
        chk("add_idle_busy", busy, 1'b0);
        step();
        req_valid = 2'b00;
        #1;
        chk("add_cmd", alu_cmd, cmd_a);
        chk("add_exec_busy", busy, 1'b1);
        chk("add_exec_ready", req_ready, 2'b00);
        chk("add_exec_rspv", rsp_valid, 1'b0);
        step();
        #1;
        chk("add_rspv", rsp_valid, 1'b1);
        chk("add_rsp_id", rsp_id, 1'b0);
        chk("add_rsp_y", rsp_y, 64'd6);
        alu_y     = 64'hDEAD_BEEF_0000_0001;
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("bp_rspv", rsp_valid, 1'b1);
            chk("bp_rsp_y", rsp_y, 64'd6);
            chk("bp_rsp_id", rsp_id, 1'b0);
            chk("bp_busy", busy, 1'b1);
            chk("bp_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("resp_done_no_ready", req_ready, 2'b00);
        step();
        #1;
        chk("bp_release_rspv", rsp_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);
        chk("hold_rsp_y", rsp_y, 64'd6);
        chk("hold_alu_cmd", alu_cmd, cmd_a);

        // ---- lone requester 0 while rr_ptr points at 1 ----
        req_bits  = {cmd_a, cmd_b};
        req_valid = 2'b01;
        alu_y     = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("lone_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        #1;
        chk("lone_rspv", rsp_valid, 1'b1);
        chk("lone_rsp_id", rsp_id, 1'b0);
        chk("lone_rsp_y", rsp_y, 64'h1234_5678_9ABC_DEF0);
        step();

        // ---- floating latency on requester 1 ----
        req_bits  = {cmd_f, cmd_b};
        req_valid = 2'b10;
        alu_y     = 64'hFEED_0000_CAFE_0003;
        #1;
        chk("fp_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        req_bits  = {cmd_r1, cmd_r0};
        #1;
        chk("fp_cmd_c1", alu_cmd, cmd_f);
        chk("fp_rspv_c1", rsp_valid, 1'b0);
        step();
        #1;
        chk("fp_cmd_c2", alu_cmd, cmd_f);
        chk("fp_rspv_c2", rsp_valid, 1'b0);
        step();
        #1;
        chk("fp_cmd_c3", alu_cmd, cmd_f);
        chk("fp_rspv_c3", rsp_valid, 1'b0);
        step();
        #1;
        chk("fp_rspv_c4", rsp_valid, 1'b1);
        chk("fp_rsp_id", rsp_id, 1'b1);
        chk("fp_rsp_y", rsp_y, 64'hFEED_0000_CAFE_0003);
        step();

        // ---- round robin from reset, both requesters valid ----
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_bits  = {cmd_r1, cmd_r0};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, ((k % 2) == 1) ? 2'b10 : 2'b01);
            step();
            #1;
            chk("rr_cmd", alu_cmd, ((k % 2) == 1) ? cmd_r1 : cmd_r0);
            chk("rr_exec_ready", req_ready, 2'b00);
            step();
            #1;
            chk("rr_rspv", rsp_valid, 1'b1);
            chk("rr_rsp_id", rsp_id, ((k % 2) == 1) ? 1'b1 : 1'b0);
            chk("rr_resp_ready", req_ready, 2'b00);
            step();
        end

        // ---- reset during EXEC, rr_ptr left at 1 beforehand ----
        req_bits  = {cmd_r1, cmd_f0};
        req_valid = 2'b01;
        #1;
        chk("rx_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        chk("rx_exec_busy", busy, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rx_alu_cmd", alu_cmd, 135'd0);
        chk("rx_rspv", rsp_valid, 1'b0);
        chk("rx_rsp_id", rsp_id, 1'b0);
        chk("rx_rsp_y", rsp_y, 64'd0);
        chk("rx_busy", busy, 1'b0);
        chk("rx_req_ready", req_ready, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("rx_no_rsp", rsp_valid, 1'b0);
        end
        req_valid = 2'b11;
        #1;
        chk("rx_grant0", req_ready, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter INT_LAT, default 1, sets the number of EXEC cycles for floating=0 commands; legal range 1..16.
REQ-002 Parameter FP_LAT, default 3, sets the number of EXEC cycles for floating=1 commands; legal range 1..16.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-005 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-006 Port `req_valid`, input, 2 bits: bit i asserts that requester i holds a command.
REQ-007 Port `req_ready`, output, 2 bits: bit i grants acceptance to requester i.
REQ-008 Port `req_bits`, input, 270 bits: slot i is at [135*i +: 135], packed MSB-first as {op[2:0], floating, form, precision[1:0], A, B, C, D}.
REQ-009 Port `alu_cmd`, output, 135 bits: registered command driven to the ALU, same packing as one req_bits slot.
REQ-010 Port `alu_y`, input, 64 bits: ALU result {Y1, Y2}.
REQ-011 Port `rsp_valid`, output, 1 bit: a response is held.
REQ-012 Port `rsp_ready`, input, 1 bit: the consumer accepts the response.
REQ-013 Port `rsp_id`, output, 1 bit: index of the requester that issued the response.
REQ-014 Port `rsp_y`, output, 64 bits: captured {Y1, Y2}.
REQ-015 Port `busy`, output, 1 bit: asserted whenever state != IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-017 Grant rule in IDLE: grant = rr_ptr if req_valid[rr_ptr] is set, otherwise the other requester if its req_valid bit is set, otherwise none.
REQ-018 req_ready SHALL be combinational: req_ready[i] = (state == IDLE) & (grant == i) & req_valid[i]; at most one bit is high; both bits are 0 outside IDLE.
REQ-019 Accept occurs on req_valid[i] & req_ready[i]; at the accepting edge the block SHALL:
- latch slot i into alu_cmd;
- set rsp_id <= i and rr_ptr <= ~i;
- load the 4-bit counter with (floating ? FP_LAT : INT_LAT) - 1;
- enter EXEC.
REQ-020 EXEC: alu_cmd SHALL be held stable; the counter decrements each cycle; on a cycle with counter == 0, the next edge SHALL set rsp_y <= alu_y and rsp_valid <= 1 and enter RESP.
REQ-021 Latency: for an accept in cycle c, rsp_valid SHALL first be high in cycle c+1+LAT, where LAT is INT_LAT or FP_LAT.
REQ-022 RESP: rsp_valid, rsp_y and rsp_id SHALL be held until rsp_valid & rsp_ready; at that edge rsp_valid <= 0 and the state returns to IDLE.
REQ-023 No acceptance SHALL occur in the RESP completion cycle; peak throughput is one command per LAT+2 cycles.
REQ-024 alu_cmd SHALL retain its last value in IDLE and RESP (no clearing); rsp_y and rsp_id SHALL retain their last values after the handshake.
REQ-025 rsp_ready while rsp_valid = 0 SHALL be ignored.
REQ-026 Deasserting req_valid before acceptance SHALL have no effect on state; req_bits are sampled only at the accepting edge.
REQ-027 A lone valid requester SHALL be granted regardless of rr_ptr, with no bubble cycle.

Reset
REQ-028 While rst = 1 at an edge, the block SHALL set:
- state = IDLE, rr_ptr = 0, counter = 0;
- alu_cmd = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0;
- busy = 0, req_ready = 0 during that cycle.
REQ-029 rst SHALL override any in-progress operation in any state: an in-flight command is discarded and no response is produced.

Verification
REQ-030 Integer add: requester 0 drives op=0, floating=0, form=1, A=1, B=2, C=3, D=2, with accept in cycle c -> alu_cmd equals slot 0 from cycle c+1; rsp_valid=1, rsp_id=0, rsp_y=6 in cycle c+2.
REQ-031 Round-robin: both req_valid held high from reset, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; one accept every 3 cycles.
REQ-032 Floating latency: floating=1, FP_LAT=3, accept in cycle c -> alu_cmd stable in cycles c+1..c+3; rsp_valid first high in cycle c+4.
REQ-033 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_y/rsp_id unchanged, busy=1, req_ready=0; rsp_ready=1 -> IDLE and rsp_valid=0 next cycle.
REQ-034 Reset in EXEC: one-cycle rst -> next cycle matches REQ-028; no rsp_valid appears; next request with both requesters valid is granted to requester 0.
REQ-035 Lone requester: after requester 0 is served (rr_ptr=1), requester 0 alone valid -> req_ready[0]=1 in the first IDLE cycle.
